// File: rtl/mod8_seq_checker.sv
// Sequence checker for a free-running modulo-2^WIDTH counter: it locks onto the count and reports errors and wraps.
// Optional build macro MOD8_CHK_GRAY_EN treats in_cnt as Gray code and decodes it to binary.
module mod8_seq_checker #(
   parameter int WIDTH    = 3,
   parameter int LOCK_CNT = 2,
   parameter int STAT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_val,
   input  logic [WIDTH-1:0]  in_cnt,
   output logic              locked,
   output logic              err,
   output logic [STAT_W-1:0] err_cnt,
   output logic [STAT_W-1:0] wrap_cnt,
   output logic [WIDTH-1:0]  last_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACQ  = 2'd1,
      ST_LOCK = 2'd2
   } state_t;

   localparam logic [3:0]        LOCK_CNT_C = 4'(LOCK_CNT);
   localparam logic [WIDTH-1:0]  CNT_MAX    = {WIDTH{1'b1}};
   localparam logic [STAT_W-1:0] STAT_MAX   = {STAT_W{1'b1}};

   state_t            state_q;
   logic [WIDTH-1:0]  prev_q;
   logic [3:0]        match_q;
   logic              locked_q;
   logic              err_q;
   logic [STAT_W-1:0] err_cnt_q;
   logic [STAT_W-1:0] wrap_cnt_q;

   logic [WIDTH-1:0]  sample_s;
   logic [WIDTH-1:0]  exp_s;
   logic [3:0]        match_inc_s;
   logic              hit_s;
   logic              wrap_s;

`ifdef MOD8_CHK_GRAY_EN
   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction
`endif

   // Decoded sample, expected successor and the comparisons against it
   always_comb begin
`ifdef MOD8_CHK_GRAY_EN
      sample_s = gray2bin(in_cnt);
`else
      sample_s = in_cnt;
`endif
      exp_s       = prev_q + WIDTH'(1);
      match_inc_s = match_q + 4'd1;
      hit_s       = (sample_s == exp_s);
      wrap_s      = (prev_q == CNT_MAX) && (sample_s == {WIDTH{1'b0}});
   end

   // Lock FSM with statistics counters; every output comes straight from a register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         prev_q     <= {WIDTH{1'b0}};
         match_q    <= 4'd0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         err_cnt_q  <= {STAT_W{1'b0}};
         wrap_cnt_q <= {STAT_W{1'b0}};
      end else begin
         err_q <= 1'b0;
         if (in_val) begin
            case (state_q)
               ST_IDLE: begin
                  prev_q   <= sample_s;
                  match_q  <= 4'd0;
                  state_q  <= ST_ACQ;
                  locked_q <= 1'b0;
               end
               ST_ACQ: begin
                  prev_q <= sample_s;
                  if (hit_s) begin
                     match_q <= match_inc_s;
                     if (match_inc_s == LOCK_CNT_C) begin
                        state_q  <= ST_LOCK;
                        locked_q <= 1'b1;
                     end else begin
                        state_q  <= ST_ACQ;
                        locked_q <= 1'b0;
                     end
                  end else begin
                     // Reseed on the new value; acquisition errors are not counted
                     match_q  <= 4'd0;
                     state_q  <= ST_ACQ;
                     locked_q <= 1'b0;
                  end
               end
               ST_LOCK: begin
                  prev_q <= sample_s;
                  if (hit_s) begin
                     locked_q <= 1'b1;
                     if (wrap_s && (wrap_cnt_q != STAT_MAX)) begin
                        wrap_cnt_q <= wrap_cnt_q + STAT_W'(1);
                     end
                  end else begin
                     err_q    <= 1'b1;
                     match_q  <= 4'd0;
                     state_q  <= ST_ACQ;
                     locked_q <= 1'b0;
                     if (err_cnt_q != STAT_MAX) begin
                        err_cnt_q <= err_cnt_q + STAT_W'(1);
                     end
                  end
               end
               default: begin
                  state_q  <= ST_IDLE;
                  match_q  <= 4'd0;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign locked   = locked_q;
   assign err      = err_q;
   assign err_cnt  = err_cnt_q;
   assign wrap_cnt = wrap_cnt_q;
   assign last_cnt = prev_q;

endmodule

// File: tb/tb_mod8_seq_checker.sv
// Self-checking bench for mod8_seq_checker: a directed vector table, randomized traffic against a history-based model, and saturation runs.
module tb_mod8_seq_checker;

   localparam int WIDTH    = 3;
   localparam int LOCK_CNT = 2;
   localparam int STAT_W   = 8;
   localparam int MOD      = 1 << WIDTH;
   localparam int SAT      = (1 << STAT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_val = 1'b0;
   logic [WIDTH-1:0]  in_cnt = '0;
   logic              locked;
   logic              err;
   logic [STAT_W-1:0] err_cnt;
   logic [STAT_W-1:0] wrap_cnt;
   logic [WIDTH-1:0]  last_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   mod8_seq_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .STAT_W(STAT_W)) dut (
      .clk(clk), .rst(rst), .in_val(in_val), .in_cnt(in_cnt),
      .locked(locked), .err(err), .err_cnt(err_cnt),
      .wrap_cnt(wrap_cnt), .last_cnt(last_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit rst; bit val; int cnt;
      int lk; int er; int ec; int wc; int lc;
   } vec_t;
   vec_t vq[$];

   // reference model: history of accepted binary samples since the last resync
   int hist[$];
   int m_ec, m_wc, m_err;

   function automatic logic [WIDTH-1:0] enc(input int b);
      logic [WIDTH-1:0] v;
      v = WIDTH'(b);
`ifdef MOD8_CHK_GRAY_EN
      return v ^ (v >> 1);
`else
      return v;
`endif
   endfunction

   function automatic int m_locked();
      return (hist.size() >= LOCK_CNT + 1) ? 1 : 0;
   endfunction

   function automatic int m_last();
      return (hist.size() == 0) ? 0 : hist[$];
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_step(input bit r, input bit v, input int b);
      int was_locked;
      m_err = 0;
      if (r) begin
         hist.delete();
         m_ec = 0;
         m_wc = 0;
      end else if (v) begin
         if (hist.size() == 0) begin
            hist.push_back(b);
         end else begin
            was_locked = m_locked();
            if (b == (hist[$] + 1) % MOD) begin
               if (was_locked != 0 && hist[$] == MOD - 1 && m_wc < SAT) m_wc++;
               hist.push_back(b);
               if (hist.size() > LOCK_CNT + 1) void'(hist.pop_front());
            end else begin
               if (was_locked != 0) begin
                  m_err = 1;
                  if (m_ec < SAT) m_ec++;
               end
               hist.delete();
               hist.push_back(b);
            end
         end
      end
   endtask

   task automatic drive(input bit r, input bit v, input int b);
      rst = r; in_val = v; in_cnt = enc(b);
      model_step(r, v, b);
      @(posedge clk); #1;
      chk("locked",   int'(locked),   m_locked());
      chk("err",      int'(err),      m_err);
      chk("err_cnt",  int'(err_cnt),  m_ec);
      chk("wrap_cnt", int'(wrap_cnt), m_wc);
      chk("last_cnt", int'(last_cnt), m_last());
   endtask

   task automatic add(input bit r, input bit v, input int c,
                      input int lk, input int er, input int ec, input int wc, input int lc);
      vec_t t;
      t.rst = r; t.val = v; t.cnt = c;
      t.lk = lk; t.er = er; t.ec = ec; t.wc = wc; t.lc = lc;
      vq.push_back(t);
   endtask

   initial begin
      int nxt, pick;

      //   rst val cnt  lk er ec wc lc
      add(1, 0, 0,   0, 0, 0, 0, 0);
      add(0, 1, 0,   0, 0, 0, 0, 0);   // seed
      add(0, 1, 1,   0, 0, 0, 0, 1);
      add(0, 1, 2,   1, 0, 0, 0, 2);   // lock on second match
      add(0, 1, 3,   1, 0, 0, 0, 3);
      add(0, 1, 4,   1, 0, 0, 0, 4);
      add(0, 1, 5,   1, 0, 0, 0, 5);
      add(0, 1, 6,   1, 0, 0, 0, 6);
      add(0, 1, 7,   1, 0, 0, 0, 7);
      add(0, 1, 0,   1, 0, 0, 1, 0);   // locked wrap
      add(0, 1, 1,   1, 0, 0, 1, 1);
      add(0, 1, 2,   1, 0, 0, 1, 2);
      add(0, 1, 3,   1, 0, 0, 1, 3);
      add(0, 1, 6,   0, 1, 1, 1, 6);   // error while locked
      add(0, 1, 7,   0, 0, 1, 1, 7);
      add(0, 1, 0,   1, 0, 1, 1, 0);   // relock; 7->0 not counted while acquiring
      for (int i = 0; i < 5; i++) add(0, 0, 5, 1, 0, 1, 1, 0);
      add(0, 1, 1,   1, 0, 1, 1, 1);
      add(0, 1, 1,   0, 1, 2, 1, 1);   // repeated value is a mismatch
      add(0, 0, 2,   0, 0, 2, 1, 1);
      add(0, 1, 2,   0, 0, 2, 1, 2);
      add(0, 1, 3,   1, 0, 2, 1, 3);
      add(0, 1, 5,   0, 1, 3, 1, 5);
      add(0, 1, 6,   0, 0, 3, 1, 6);
      add(0, 1, 7,   1, 0, 3, 1, 7);
      add(1, 1, 0,   0, 0, 0, 0, 0);   // reset mid-lock with valid high
      add(0, 1, 4,   0, 0, 0, 0, 4);
      add(0, 1, 5,   0, 0, 0, 0, 5);
      add(0, 1, 6,   1, 0, 0, 0, 6);
      add(0, 1, 0,   0, 1, 1, 0, 0);
      add(1, 1, 1,   0, 0, 0, 0, 0);   // reset right after an error pulse
      add(0, 1, 3,   0, 0, 0, 0, 3);

      for (int i = 0; i < vq.size(); i++) begin
         rst = vq[i].rst; in_val = vq[i].val; in_cnt = enc(vq[i].cnt);
         @(posedge clk); #1;
         chk($sformatf("v%0d.locked", i),   int'(locked),   vq[i].lk);
         chk($sformatf("v%0d.err", i),      int'(err),      vq[i].er);
         chk($sformatf("v%0d.err_cnt", i),  int'(err_cnt),  vq[i].ec);
         chk($sformatf("v%0d.wrap_cnt", i), int'(wrap_cnt), vq[i].wc);
         chk($sformatf("v%0d.last_cnt", i), int'(last_cnt), vq[i].lc);
      end

      // randomized traffic against the model
      drive(1'b1, 1'b0, 0);
      for (int i = 0; i < 2000; i++) begin
         pick = int'($urandom_range(99));
         if (pick < 75)      nxt = (m_last() + 1) % MOD;
         else if (pick < 85) nxt = m_last();
         else                nxt = int'($urandom_range(MOD - 1));
         drive(($urandom_range(199) == 0), ($urandom_range(3) != 0), nxt);
      end

      // err_cnt saturation: lock, then break the sequence, repeatedly
      drive(1'b1, 1'b0, 0);
      drive(1'b0, 1'b1, 0);
      for (int i = 0; i < 270; i++) begin
         drive(1'b0, 1'b1, (m_last() + 1) % MOD);
         drive(1'b0, 1'b1, (m_last() + 1) % MOD);
         drive(1'b0, 1'b1, m_last());
      end
      chk("err_cnt_saturated", int'(err_cnt), SAT);

      // wrap_cnt saturation: clean count for many laps
      drive(1'b1, 1'b0, 0);
      for (int i = 0; i < 270 * MOD; i++) drive(1'b0, 1'b1, i % MOD);
      chk("wrap_cnt_saturated", int'(wrap_cnt), SAT);
      chk("err_cnt_clean", int'(err_cnt), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
